// File: rtl/ram_result_writeback.sv
// Copies 1-3 result chunks from RAM A/B into RAM C/D on command 4'h6, then pulses interupt.
// Optional RAM_RESULT_WRITEBACK_BYTE_SWAP_EN byte-reverses each copied word.
module ram_result_writeback #(
   parameter int DATA_W = 256,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        command,
   input  logic [ADDR_W-1:0] read_addr,
   input  logic [ADDR_W-1:0] write_addr,
   input  logic [1:0]        numbr_of_chunk,
   input  logic              select_Ram_A_Or_B,
   input  logic              select_Ram_C_Or_D,
   input  logic [DATA_W-1:0] a_dout,
   input  logic [DATA_W-1:0] b_dout,
   output logic [ADDR_W-1:0] a_adbus,
   output logic [ADDR_W-1:0] b_adbus,
   output logic              c_w,
   output logic [ADDR_W-1:0] c_adbus,
   output logic              d_w,
   output logic [ADDR_W-1:0] d_adbus,
   output logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              interupt
);

   typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_DONE} state_t;

   state_t            state, state_nx;
   logic [ADDR_W-1:0] rd_base, wr_base;
   logic [1:0]        count, k;
   logic              sel_ab, sel_cd;
   logic              accept, last_chunk;
   logic [DATA_W-1:0] src_word;

   assign accept     = (state == S_IDLE) && (command == 4'h6);
   assign last_chunk = (k == count - 2'd1);
   assign src_word   = sel_ab ? a_dout : b_dout;

   function automatic logic [DATA_W-1:0] fmt_word(input logic [DATA_W-1:0] w);
      logic [DATA_W-1:0] r;
`ifdef RAM_RESULT_WRITEBACK_BYTE_SWAP_EN
      r = '0;
      for (int unsigned i = 0; i < DATA_W / 8; i++)
         r[8*i +: 8] = w[DATA_W-8-8*i +: 8];
`else
      r = w;
`endif
      return r;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: if (accept) state_nx = (numbr_of_chunk == 2'd0) ? S_DONE : S_RD;
         S_RD:   state_nx = S_WAIT;
         S_WAIT: state_nx = S_WR;
         S_WR:   state_nx = last_chunk ? S_DONE : S_RD;
         S_DONE: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Every output is loaded one edge ahead so it is valid for the whole cycle of its state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_base  <= '0;
         wr_base  <= '0;
         count    <= '0;
         k        <= '0;
         sel_ab   <= 1'b0;
         sel_cd   <= 1'b0;
         a_adbus  <= '0;
         b_adbus  <= '0;
         c_adbus  <= '0;
         d_adbus  <= '0;
         c_w      <= 1'b0;
         d_w      <= 1'b0;
         wr_data  <= '0;
         busy     <= 1'b0;
         interupt <= 1'b0;
      end else begin
         busy     <= (state_nx != S_IDLE);
         interupt <= (state_nx == S_DONE);
         c_w      <= 1'b0;
         d_w      <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  rd_base <= read_addr;
                  wr_base <= write_addr;
                  count   <= numbr_of_chunk;
                  sel_ab  <= select_Ram_A_Or_B;
                  sel_cd  <= select_Ram_C_Or_D;
                  k       <= '0;
                  if (numbr_of_chunk != 2'd0) begin
                     if (select_Ram_A_Or_B) a_adbus <= read_addr;
                     else                   b_adbus <= read_addr;
                  end
               end
            end
            S_WAIT: begin
               wr_data <= fmt_word(src_word);
               if (sel_cd) begin
                  c_w     <= 1'b1;
                  c_adbus <= wr_base - ADDR_W'(k);
               end else begin
                  d_w     <= 1'b1;
                  d_adbus <= wr_base - ADDR_W'(k);
               end
            end
            S_WR: begin
               if (!last_chunk) begin
                  k <= k + 2'd1;
                  if (sel_ab) a_adbus <= rd_base - ADDR_W'(k + 2'd1);
                  else        b_adbus <= rd_base - ADDR_W'(k + 2'd1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_result_writeback.sv
// Randomized bench for ram_result_writeback with RAM models and a transfer-level reference model.
// Honours RAM_RESULT_WRITEBACK_BYTE_SWAP_EN when defined.
module tb_ram_result_writeback;
   localparam int DATA_W = 256;
   localparam int ADDR_W = 3;
   localparam int DEPTH  = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [3:0]        command;
   logic [ADDR_W-1:0] read_addr, write_addr;
   logic [1:0]        numbr_of_chunk;
   logic              select_Ram_A_Or_B, select_Ram_C_Or_D;
   logic [DATA_W-1:0] a_dout, b_dout;
   logic [ADDR_W-1:0] a_adbus, b_adbus, c_adbus, d_adbus;
   logic              c_w, d_w, busy, interupt;
   logic [DATA_W-1:0] wr_data;

   logic [DATA_W-1:0] a_mem [DEPTH];
   logic [DATA_W-1:0] b_mem [DEPTH];
   logic [DATA_W-1:0] c_mem [DEPTH];
   logic [DATA_W-1:0] d_mem [DEPTH];
   logic [DATA_W-1:0] exp_c [DEPTH];
   logic [DATA_W-1:0] exp_d [DEPTH];
   logic              mem_clr;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ram_result_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .command(command),
      .read_addr(read_addr), .write_addr(write_addr), .numbr_of_chunk(numbr_of_chunk),
      .select_Ram_A_Or_B(select_Ram_A_Or_B), .select_Ram_C_Or_D(select_Ram_C_Or_D),
      .a_dout(a_dout), .b_dout(b_dout),
      .a_adbus(a_adbus), .b_adbus(b_adbus),
      .c_w(c_w), .c_adbus(c_adbus), .d_w(d_w), .d_adbus(d_adbus),
      .wr_data(wr_data), .busy(busy), .interupt(interupt)
   );

   // Synchronous RAMs: 1-cycle read latency, write at the edge ending the write-enable cycle.
   always @(posedge clk) begin
      a_dout <= a_mem[a_adbus];
      b_dout <= b_mem[b_adbus];
      if (mem_clr) begin
         for (int i = 0; i < DEPTH; i++) begin
            c_mem[i] <= '0;
            d_mem[i] <= '0;
         end
      end else begin
         if (c_w) c_mem[c_adbus] <= wr_data;
         if (d_w) d_mem[d_adbus] <= wr_data;
      end
   end

   function automatic logic [DATA_W-1:0] xform(input logic [DATA_W-1:0] w);
      logic [DATA_W-1:0] r;
`ifdef RAM_RESULT_WRITEBACK_BYTE_SWAP_EN
      r = {<<8{w}};
`else
      r = w;
`endif
      return r;
   endfunction

   task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   task automatic check_mems();
      for (int i = 0; i < DEPTH; i++) begin
         check($sformatf("c_mem[%0d]", i), c_mem[i], exp_c[i]);
         check($sformatf("d_mem[%0d]", i), d_mem[i], exp_d[i]);
      end
   endtask

   // Called at a negedge with the DUT idle; the accept edge ends the current cycle.
   task automatic run_xfer(input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] wa,
                           input logic [1:0] n, input logic sa, input logic sc, input bit disturb);
      logic [ADDR_W-1:0] a0, b0, c0, d0, sidx, didx;
      logic [DATA_W-1:0] sw;
      logic [3:0]        want_flags;
      int                last_t, j, ph;
      check("idle_busy", DATA_W'(busy), '0);
      a0 = a_adbus; b0 = b_adbus; c0 = c_adbus; d0 = d_adbus;
      read_addr = ra; write_addr = wa; numbr_of_chunk = n;
      select_Ram_A_Or_B = sa; select_Ram_C_Or_D = sc; command = 4'h6;
      for (int q = 0; q < int'(n); q++) begin
         sidx = ra - ADDR_W'(q);
         didx = wa - ADDR_W'(q);
         sw   = xform(sa ? a_mem[sidx] : b_mem[sidx]);
         if (sc) exp_c[didx] = sw;
         else    exp_d[didx] = sw;
      end
      @(negedge clk);
      command = 4'h0;
      last_t = 3 * int'(n) + 1;
      for (int t = 1; t <= last_t; t++) begin
         j  = (t - 1) / 3;
         ph = (t - 1) % 3;
         sidx = ra - ADDR_W'(j);
         didx = wa - ADDR_W'(j);
         if (t == last_t)  want_flags = 4'b1100;
         else if (ph == 2) want_flags = {2'b10, sc, ~sc};
         else              want_flags = 4'b1000;
         check($sformatf("flags t=%0d", t), DATA_W'({busy, interupt, c_w, d_w}), DATA_W'(want_flags));
         if (t != last_t && ph == 0)
            check($sformatf("src_addr j=%0d", j), DATA_W'(sa ? a_adbus : b_adbus), DATA_W'(sidx));
         if (t != last_t && ph == 2) begin
            check($sformatf("dst_addr j=%0d", j), DATA_W'(sc ? c_adbus : d_adbus), DATA_W'(didx));
            check($sformatf("wr_data j=%0d", j), wr_data, xform(sa ? a_mem[sidx] : b_mem[sidx]));
         end
         if (disturb) begin
            command           = (t == last_t) ? 4'h0 : ($urandom_range(0, 1) == 1 ? 4'h6 : 4'($urandom));
            select_Ram_A_Or_B = 1'($urandom);
            select_Ram_C_Or_D = 1'($urandom);
            read_addr         = ADDR_W'($urandom);
            write_addr        = ADDR_W'($urandom);
            numbr_of_chunk    = 2'($urandom);
         end
         @(negedge clk);
      end
      command = 4'h0;
      check("after_done", DATA_W'({busy, interupt, c_w, d_w}), '0);
      if (n == 2'd0) begin
         check("zero_adbus", DATA_W'({a_adbus, b_adbus, c_adbus, d_adbus}), DATA_W'({a0, b0, c0, d0}));
      end else begin
         check("unsel_src", DATA_W'(sa ? b_adbus : a_adbus), DATA_W'(sa ? b0 : a0));
         check("unsel_dst", DATA_W'(sc ? d_adbus : c_adbus), DATA_W'(sc ? d0 : c0));
      end
      check_mems();
   endtask

   initial begin
      logic [DATA_W-1:0] pat, pat_sw;
      rst_n = 1'b0; mem_clr = 1'b1; command = 4'h0;
      read_addr = '0; write_addr = '0; numbr_of_chunk = '0;
      select_Ram_A_Or_B = 1'b0; select_Ram_C_Or_D = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         a_mem[i] = {8{$urandom()}};
         b_mem[i] = {8{$urandom()}};
         exp_c[i] = '0;
         exp_d[i] = '0;
      end
      repeat (2) @(negedge clk);
      check("rst_flags", DATA_W'({busy, interupt, c_w, d_w}), '0);
      check("rst_adbus", DATA_W'({a_adbus, b_adbus, c_adbus, d_adbus}), '0);
      check("rst_wr_data", wr_data, '0);
      rst_n = 1'b1; mem_clr = 1'b0;
      @(negedge clk);

      run_xfer(3'd5, 3'd7, 2'd3, 1'b1, 1'b1, 1'b0);   // three chunks A->C
      run_xfer(3'd0, 3'd1, 2'd2, 1'b0, 1'b0, 1'b0);   // wrap-around B->D
      run_xfer(3'd4, 3'd2, 2'd0, 1'b1, 1'b0, 1'b0);   // zero chunks
      run_xfer(3'd2, 3'd6, 2'd3, 1'b0, 1'b1, 1'b1);   // ignored commands mid-transfer
      run_xfer(3'd6, 3'd3, 2'd1, 1'b1, 1'b0, 1'b0);   // back-to-back accept

      for (int r = 0; r < 16; r++)
         run_xfer(ADDR_W'($urandom), ADDR_W'($urandom), 2'($urandom), 1'($urandom),
                  1'($urandom), bit'($urandom_range(0, 1)));

      // Reset during WAIT of chunk 1 of 3: only chunk 0 lands.
      read_addr = 3'd1; write_addr = 3'd4; numbr_of_chunk = 2'd3;
      select_Ram_A_Or_B = 1'b1; select_Ram_C_Or_D = 1'b1; command = 4'h6;
      exp_c[3'd4] = xform(a_mem[3'd1]);
      @(negedge clk);
      command = 4'h0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_flags", DATA_W'({busy, interupt, c_w, d_w}), '0);
      check("mid_rst_adbus", DATA_W'({a_adbus, b_adbus, c_adbus, d_adbus}), '0);
      check("mid_rst_wr_data", wr_data, '0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int t = 0; t < 8; t++) begin
         @(negedge clk);
         check($sformatf("post_rst t=%0d", t), DATA_W'({busy, interupt, c_w, d_w}), '0);
      end
      check_mems();

      // Byte-order check on a known pattern 0x0102...1F20 at A[0].
      for (int i = 0; i < DATA_W / 8; i++) begin
         pat[8*(DATA_W/8-1-i) +: 8] = 8'(i + 1);
         pat_sw[8*i +: 8]           = 8'(i + 1);
      end
      a_mem[0] = pat;
      run_xfer(3'd0, 3'd0, 2'd1, 1'b1, 1'b1, 1'b0);
`ifdef RAM_RESULT_WRITEBACK_BYTE_SWAP_EN
      check("byte_order", c_mem[0], pat_sw);
`else
      check("byte_order", c_mem[0], pat);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
